fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised instruction prefetch buffer between fetch and decode, replacing the
//   single fetch-decode register pair. Holds up to DEPTH fetched {inst, pc} entries so
//   fetch keeps running while decode is stalled by the hazard unit. Squashes all
//   entries on a branch/jump redirect from execute. Presents a NOP bubble when empty.
// PARAMETERS
//   XLEN      32            data/address width of inst and pc
//   DEPTH     4             entry count; power of two, >= 2
//   NOP_INST  32'h00000013  instruction driven on o_inst when empty (addi x0,x0,0)
//   CNT_W     16            width of saturating flush counter
// PORTS
//   clk           in   1                     rising-edge clock
//   reset         in   1                     asynchronous, active-high reset
//   i_valid       in   1                     fetch presents an entry this cycle
//   i_inst        in   XLEN                  fetched instruction
//   i_pc          in   XLEN                  pc of fetched instruction
//   o_ready       out  1                     queue accepts a push this cycle
//   o_valid       out  1                     head entry valid toward decode
//   o_inst        out  XLEN                  head instruction (NOP_INST when empty)
//   o_pc          out  XLEN                  head pc (0 when empty)
//   o_pc_inc      out  XLEN                  head pc + 4 (0 when empty)
//   i_stall       in   1                     decode holds; no pop this cycle
//   i_flush       in   1                     redirect; discard all entries
//   o_count       out  $clog2(DEPTH)+1       current occupancy
//   o_flush_cnt   out  CNT_W                 number of flushes that discarded >=1 entry
// BEHAVIOUR
//   - One clock (clk); reset asynchronous, active-high: count, rd/wr pointers,
//     o_flush_cnt -> 0 immediately; storage contents undefined, not reset.
//   - Reset values of outputs: o_valid 0, o_inst NOP_INST, o_pc 0, o_pc_inc 0,
//     o_count 0, o_flush_cnt 0, o_ready 1 (pushes ignored while reset is high).
//   - o_ready = (count != DEPTH); depends only on registered count, not on i_stall.
//   - push = i_valid & o_ready & !i_flush; pop = o_valid & !i_stall & !i_flush.
//   - Push writes at wr_ptr; pop advances rd_ptr; pointers wrap modulo DEPTH.
//   - Latency: no bypass; a pushed entry appears on o_* the cycle after the push edge.
//   - Head outputs combinational from storage at rd_ptr; o_valid = (count != 0).
//   - o_pc_inc = o_pc + 4, truncated to XLEN bits (wraps at 2^XLEN).
//   - Simultaneous push and pop (0 < count < DEPTH): count unchanged, both pointers move.
//   - Full: o_ready 0; a pop in the same cycle does NOT enable a push (no pass-through).
//   - Empty with i_stall 0: nothing popped; outputs stay at NOP/0 values.
//   - Flush has priority over push and pop: next edge count 0, rd_ptr = wr_ptr = 0;
//     incoming i_valid entry in the flush cycle is dropped.
//   - o_flush_cnt increments on a flush edge only if count != 0; saturates at 2^CNT_W-1.
//   - Stall with count == DEPTH and i_valid 1: entry held upstream, none lost.
//   - Reset asserted mid-operation: queue empties asynchronously; first push after
//     reset release lands in slot 0.
// TESTING
//   1 Reset, push inst 0x00500093 pc 0x0 -> next cycle o_valid 1, o_pc 0x0, o_pc_inc 0x4.
//   2 DEPTH=4, i_stall 1, push 5 entries pc 0x0..0x10 -> o_count 4, o_ready 0,
//     pc 0x10 held; release stall -> pops 0x0,0x4,0x8,0xC in order, then 0x10 accepted.
//   3 count 2, i_flush 1 with i_valid 1 -> next cycle o_count 0, o_inst 0x00000013,
//     o_flush_cnt 1; flush with count 0 -> o_flush_cnt stays 1.
//   4 Continuous push+pop for 10 cycles, i_stall 0 -> o_count stays 1, pointers wrap,
//     pcs 0x0..0x24 emerge in order with no gaps.
//   5 Head pc 0xFFFFFFFC -> o_pc_inc 0x00000000.
//   6 Reset pulsed while count 3 -> o_valid 0 same cycle; CNT_W=2, 5 non-empty
//     flushes -> o_flush_cnt saturates at 3.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction prefetch buffer between fetch and decode. Holds up to DEPTH
//   {inst, pc} entries so fetch can run ahead while decode is stalled.
//   A redirect (i_flush) discards every entry. When empty, the head presents
//   a NOP bubble with pc/pc_inc forced to zero.
//
//   Ports
//     clk, reset          rising-edge clock, async active-high reset
//     i_valid/i_inst/i_pc fetch-side push request and payload
//     o_ready             queue can take a push (registered occupancy only)
//     o_valid/o_inst/o_pc head entry toward decode (NOP / 0 when empty)
//     o_pc_inc            head pc + 4, wraps at 2^XLEN (0 when empty)
//     i_stall             decode holds the head this cycle
//     i_flush             redirect, empties the queue; wins over push/pop
//     o_count             current occupancy
//     o_flush_cnt         saturating count of flushes that dropped >=1 entry
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013),
    parameter int unsigned     CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic [XLEN-1:0]          i_inst,
    input  logic [XLEN-1:0]          i_pc,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [XLEN-1:0]          o_inst,
    output logic [XLEN-1:0]          o_pc,
    output logic [XLEN-1:0]          o_pc_inc,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [CNT_W-1:0]         o_flush_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] FLUSH_MAX = {CNT_W{1'b1}};

    // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("fetch_queue: DEPTH must be a power of two and >= 2");
    end

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    entry_t             head;

    // Occupancy flags come only from registered state.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A pop never frees a slot for a push in the same cycle (no pass-through).
    assign push = i_valid & ~full & ~i_flush;
    assign pop  = ~empty & ~i_stall & ~i_flush;

    // Next-state for pointers, occupancy and flush statistics.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        flush_cnt_d = flush_cnt_q;

        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (!empty && (flush_cnt_q != FLUSH_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= '{inst: i_inst, pc: i_pc};
        end
    end

    assign head = mem_q[rd_ptr_q];

    // Head view toward decode; an empty queue shows a bubble.
    always_comb begin
        o_inst   = NOP_INST;
        o_pc     = '0;
        o_pc_inc = '0;
        if (!empty) begin
            o_inst   = head.inst;
            o_pc     = head.pc;
            o_pc_inc = head.pc + XLEN'(4);
        end
    end

    assign o_ready     = ~full;
    assign o_valid     = ~empty;
    assign o_count     = count_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Drives two fetch_queue instances (flush counter 16 and 2 bits wide) from
//   the same stimulus and compares them with a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_inst;
    logic [31:0] i_pc;
    logic        i_stall;
    logic        i_flush;

    logic        o_ready,  o_valid;
    logic [31:0] o_inst,   o_pc,   o_pc_inc;
    logic [2:0]  o_count;
    logic [15:0] o_flush_cnt;

    logic        r2_ready, r2_valid;
    logic [31:0] r2_inst,  r2_pc,  r2_pc_inc;
    logic [2:0]  r2_count;
    logic [1:0]  r2_flush_cnt;

    int          checks   = 0;
    int          failures = 0;

    ent_t        mq[$];
    int          mf16;
    int          mf2;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP_INST(NOP), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
        .o_ready(o_ready), .o_valid(o_valid), .o_inst(o_inst),
        .o_pc(o_pc), .o_pc_inc(o_pc_inc),
        .i_stall(i_stall), .i_flush(i_flush),
        .o_count(o_count), .o_flush_cnt(o_flush_cnt)
    );

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP_INST(NOP), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
        .o_ready(r2_ready), .o_valid(r2_valid), .o_inst(r2_inst),
        .o_pc(r2_pc), .o_pc_inc(r2_pc_inc),
        .i_stall(i_stall), .i_flush(i_flush),
        .o_count(r2_count), .o_flush_cnt(r2_flush_cnt)
    );

    // Expected head view derived from the model queue.
    function automatic logic [31:0] exp_inst();
        return (mq.size() != 0) ? mq[0].inst : NOP;
    endfunction
    function automatic logic [31:0] exp_pc();
        return (mq.size() != 0) ? mq[0].pc : 32'h0;
    endfunction
    function automatic logic [31:0] exp_pc_inc();
        logic [31:0] p;
        p = mq[0].pc + 32'd4;
        return (mq.size() != 0) ? p : 32'h0;
    endfunction

    // One clock of stimulus plus the matching model update.
    task automatic tick(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic st, input logic fl);
        bit   push;
        bit   pop;
        ent_t e;
        i_valid = v; i_inst = inst; i_pc = pc; i_stall = st; i_flush = fl;
        push = v && (mq.size() < DEPTH) && !fl;
        pop  = (mq.size() != 0) && !st && !fl;
        e.inst = inst;
        e.pc   = pc;
        @(posedge clk);
        #1;
        if (fl) begin
            if (mq.size() != 0) begin
                if (mf16 < 65535) mf16++;
                if (mf2 < 3) mf2++;
            end
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    endtask

    task automatic do_reset();
        i_valid = 1'b0; i_inst = '0; i_pc = '0; i_stall = 1'b0; i_flush = 1'b0;
        reset = 1'b1;
        mq.delete(); mf16 = 0; mf2 = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        i_valid = 1'b0; i_inst = '0; i_pc = '0; i_stall = 1'b0; i_flush = 1'b0;
        reset = 1'b1;
        mq.delete(); mf16 = 0; mf2 = 0;
        #2;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", o_valid); end
        checks++; if (o_inst !== NOP) begin failures++; $display("FAIL rst_inst got=%h exp=%h", o_inst, NOP); end
        checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", o_pc); end
        checks++; if (o_pc_inc !== 32'h0) begin failures++; $display("FAIL rst_pc_inc got=%h exp=0", o_pc_inc); end
        checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", o_count); end
        checks++; if (o_flush_cnt !== 16'd0) begin failures++; $display("FAIL rst_flush_cnt got=%0d exp=0", o_flush_cnt); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", o_ready); end
        // Pushes while reset is high are ignored.
        i_valid = 1'b1; i_inst = 32'hdead_beef; i_pc = 32'h100;
        @(posedge clk);
        #1;
        checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL rst_push_ignored got=%0d exp=0", o_count); end
        checks++; if (r2_valid !== 1'b0) begin failures++; $display("FAIL rst_valid2 got=%0b exp=0", r2_valid); end
        i_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_push();
        do_reset();
        tick(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", o_valid); end
        checks++; if (o_inst !== 32'h0050_0093) begin failures++; $display("FAIL single_inst got=%h exp=00500093", o_inst); end
        checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL single_pc got=%h exp=0", o_pc); end
        checks++; if (o_pc_inc !== 32'h4) begin failures++; $display("FAIL single_pc_inc got=%h exp=4", o_pc_inc); end
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", o_valid); end
    endtask

    task automatic test_full_stall();
        logic [31:0] order [5];
        int          idx;
        bit          pending;
        bit          accept;
        order = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        do_reset();
        for (int k = 0; k < 4; k++) tick(1'b1, $urandom, 32'(4 * k), 1'b1, 1'b0);
        checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", o_count); end
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", o_ready); end
        tick(1'b1, 32'h1111_0013, 32'h10, 1'b1, 1'b0);
        checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL full_hold_count got=%0d exp=4", o_count); end
        checks++; if (o_pc !== 32'h0) begin failures++; $display("FAIL full_hold_head got=%h exp=0", o_pc); end
        idx = 0;
        pending = 1'b1;
        for (int cyc = 0; cyc < 20 && idx < 5; cyc++) begin
            checks++; if (o_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL full_rel_ready cyc=%0d got=%0b exp=%0b", cyc, o_ready, mq.size() != DEPTH); end
            if (o_valid) begin
                checks++; if (o_pc !== order[idx]) begin failures++; $display("FAIL full_order idx=%0d got=%h exp=%h", idx, o_pc, order[idx]); end
                idx++;
            end
            accept = pending && o_ready;
            tick(pending, 32'h1111_0013, 32'h10, 1'b0, 1'b0);
            if (accept) pending = 1'b0;
        end
        checks++; if (idx !== 5) begin failures++; $display("FAIL full_drain_count got=%0d exp=5", idx); end
    endtask

    task automatic test_flush();
        do_reset();
        tick(1'b1, $urandom, 32'h20, 1'b1, 1'b0);
        tick(1'b1, $urandom, 32'h24, 1'b1, 1'b0);
        checks++; if (o_count !== 3'd2) begin failures++; $display("FAIL flush_pre_count got=%0d exp=2", o_count); end
        tick(1'b1, $urandom, 32'h28, 1'b0, 1'b1);
        checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", o_count); end
        checks++; if (o_inst !== NOP) begin failures++; $display("FAIL flush_inst got=%h exp=%h", o_inst, NOP); end
        checks++; if (o_flush_cnt !== 16'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", o_flush_cnt); end
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checks++; if (o_flush_cnt !== 16'd1) begin failures++; $display("FAIL flush_empty_cnt got=%0d exp=1", o_flush_cnt); end
        // First push after a flush lands at the head.
        tick(1'b1, 32'h0000_0113, 32'h80, 1'b1, 1'b0);
        checks++; if (o_pc !== 32'h80) begin failures++; $display("FAIL flush_repush_pc got=%h exp=80", o_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1'b1, $urandom, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k < 10; k++) begin
            tick(1'b1, $urandom, 32'(4 * k), 1'b0, 1'b0);
            checks++; if (o_count !== 3'd1) begin failures++; $display("FAIL b2b_count k=%0d got=%0d exp=1", k, o_count); end
            checks++; if (o_pc !== 32'(4 * k)) begin failures++; $display("FAIL b2b_pc k=%0d got=%h exp=%h", k, o_pc, 32'(4 * k)); end
            checks++; if (o_inst !== exp_inst()) begin failures++; $display("FAIL b2b_inst k=%0d got=%h exp=%h", k, o_inst, exp_inst()); end
        end
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", o_valid); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        tick(1'b1, $urandom, 32'hFFFF_FFFC, 1'b1, 1'b0);
        checks++; if (o_pc_inc !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%h exp=0", o_pc_inc); end
        checks++; if (o_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL pc_wrap_pc got=%h exp=fffffffc", o_pc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) tick(1'b1, $urandom, 32'(32'h200 + 4 * k), 1'b1, 1'b0);
        tick(1'b1, $urandom, 32'h300, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b1, $urandom, 32'(32'h400 + 4 * k), 1'b1, 1'b0);
        checks++; if (o_count !== 3'd3) begin failures++; $display("FAIL rmid_pre_count got=%0d exp=3", o_count); end
        #2;
        reset = 1'b1;
        mq.delete(); mf16 = 0; mf2 = 0;
        #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0b exp=0", o_valid); end
        checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", o_count); end
        checks++; if (o_flush_cnt !== 16'd0) begin failures++; $display("FAIL rmid_flush_cnt got=%0d exp=0", o_flush_cnt); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1'b1, 32'h0000_0213, 32'h500, 1'b1, 1'b0);
        tick(1'b1, 32'h0000_0313, 32'h504, 1'b1, 1'b0);
        checks++; if (o_pc !== 32'h500) begin failures++; $display("FAIL rmid_repush_pc got=%h exp=500", o_pc); end
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (o_pc !== 32'h504) begin failures++; $display("FAIL rmid_second_pc got=%h exp=504", o_pc); end
    endtask

    task automatic test_flush_saturate();
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            tick(1'b1, $urandom, 32'(n * 8), 1'b1, 1'b0);
            tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
            checks++; if (r2_flush_cnt !== 2'((n > 3) ? 3 : n)) begin failures++; $display("FAIL sat_cnt2 n=%0d got=%0d exp=%0d", n, r2_flush_cnt, (n > 3) ? 3 : n); end
            checks++; if (o_flush_cnt !== 16'(n)) begin failures++; $display("FAIL sat_cnt16 n=%0d got=%0d exp=%0d", n, o_flush_cnt, n); end
        end
    endtask

    task automatic test_random();
        logic v, st, fl;
        logic [31:0] pc;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++; if (o_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, o_valid, mq.size() != 0); end
            checks++; if (o_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, o_ready, mq.size() != DEPTH); end
            checks++; if (o_count !== 3'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, o_count, mq.size()); end
            checks++; if (o_inst !== exp_inst()) begin failures++; $display("FAIL rnd_inst cyc=%0d got=%h exp=%h", cyc, o_inst, exp_inst()); end
            checks++; if (o_pc !== exp_pc()) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, o_pc, exp_pc()); end
            checks++; if (o_pc_inc !== exp_pc_inc()) begin failures++; $display("FAIL rnd_pc_inc cyc=%0d got=%h exp=%h", cyc, o_pc_inc, exp_pc_inc()); end
            checks++; if (o_flush_cnt !== 16'(mf16)) begin failures++; $display("FAIL rnd_flush_cnt cyc=%0d got=%0d exp=%0d", cyc, o_flush_cnt, mf16); end
            checks++; if (r2_flush_cnt !== 2'(mf2)) begin failures++; $display("FAIL rnd_flush_cnt2 cyc=%0d got=%0d exp=%0d", cyc, r2_flush_cnt, mf2); end
            checks++; if (r2_pc !== exp_pc()) begin failures++; $display("FAIL rnd_pc2 cyc=%0d got=%h exp=%h", cyc, r2_pc, exp_pc()); end
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 15) == 0);
            pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            tick(v, $urandom, pc, st, fl);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        i_valid = 1'b0; i_inst = '0; i_pc = '0; i_stall = 1'b0; i_flush = 1'b0;
        mf16 = 0; mf2 = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_push();
        test_full_stall();
        test_flush();
        test_back_to_back();
        test_pc_wrap();
        test_reset_mid();
        test_flush_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
